// File: rtl/window_gen_kxk.sv
// rtl/window_gen_kxk.sv - streaming KxK sliding-window generator with runtime size, stride 1/2 and backpressure
module window_gen_kxk #(
  parameter int DATA_W     = 8,
  parameter int K          = 3,
  parameter int MAX_WIDTH  = 64,
  parameter int MAX_HEIGHT = 64,
  localparam int CW = $clog2(MAX_WIDTH + 1),
  localparam int RW = $clog2(MAX_HEIGHT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CW-1:0]         cfg_width,
  input  logic [RW-1:0]         cfg_height,
  input  logic                  cfg_stride,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [K*K*DATA_W-1:0] win_data,
  output logic [RW-1:0]         win_row,
  output logic [CW-1:0]         win_col,
  output logic                  win_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  cfg_err
);
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  logic [RW-1:0] row, height_r, h_clamp, eff_height, last_row;
  logic [CW-1:0] col, width_r, w_clamp, eff_width, last_col;
  logic          row_ph, col_ph, stride_r, eff_stride, w_err, h_err;
  logic          first, accept, emit, end_col, end_row;
  logic [AW-1:0] col_idx;

  // cur_col: the column of K pixels ending at the incoming pixel, row r at [r*DATA_W]
  logic [K*DATA_W-1:0]       cur_col;
  logic [(K-1)*K*DATA_W-1:0] hist;
  logic [K*K*DATA_W-1:0]     cols;
  logic [K*K*DATA_W-1:0]     win_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign first    = (row == '0) && (col == '0);
  assign col_idx  = col[AW-1:0];

  always_comb begin
    w_clamp = cfg_width;
    w_err   = 1'b0;
    h_clamp = cfg_height;
    h_err   = 1'b0;
    if (cfg_width < CW'(K)) begin
      w_clamp = CW'(K);
      w_err   = 1'b1;
    end else if (cfg_width > CW'(MAX_WIDTH)) begin
      w_clamp = CW'(MAX_WIDTH);
      w_err   = 1'b1;
    end
    if (cfg_height < RW'(K)) begin
      h_clamp = RW'(K);
      h_err   = 1'b1;
    end else if (cfg_height > RW'(MAX_HEIGHT)) begin
      h_clamp = RW'(MAX_HEIGHT);
      h_err   = 1'b1;
    end
  end

  // The first pixel of a frame uses the live config; later pixels use the captured one
  assign eff_width  = first ? w_clamp : width_r;
  assign eff_height = first ? h_clamp : height_r;
  assign eff_stride = first ? cfg_stride : stride_r;

  // Pixel that completes the final window: last stride-aligned origin plus K-1
  assign last_row = eff_stride ? (((eff_height - RW'(K)) & {{(RW-1){1'b1}}, 1'b0}) + RW'(K-1))
                               : (eff_height - RW'(1));
  assign last_col = eff_stride ? (((eff_width - CW'(K)) & {{(CW-1){1'b1}}, 1'b0}) + CW'(K-1))
                               : (eff_width - CW'(1));

  assign end_col = (col == eff_width - CW'(1));
  assign end_row = (row == eff_height - RW'(1));
  assign emit    = (row >= RW'(K-1)) && (col >= CW'(K-1)) &&
                   (!eff_stride || (!row_ph && !col_ph));

  // Line buffer r holds image row (current_row - K + 1 + r) for columns not yet overwritten
  for (genvar r = 0; r < K-1; r++) begin : g_line
    logic [DATA_W-1:0] mem [MAX_WIDTH];
    always_ff @(posedge clk) begin
      if (accept) mem[col_idx] <= cur_col[(r+1)*DATA_W +: DATA_W];
    end
    assign cur_col[r*DATA_W +: DATA_W] = mem[col_idx];
  end
  assign cur_col[(K-1)*DATA_W +: DATA_W] = in_data;

  assign cols = {cur_col, hist};

  always_comb begin
    win_next = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win_next[(r*K+c)*DATA_W +: DATA_W] = cols[(c*K+r)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (accept) hist <= cols[K*K*DATA_W-1:K*DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      col        <= '0;
      row_ph     <= 1'b0;
      col_ph     <= 1'b0;
      width_r    <= '0;
      height_r   <= '0;
      stride_r   <= 1'b0;
      cfg_err    <= 1'b0;
      out_valid  <= 1'b0;
      win_data   <= '0;
      win_row    <= '0;
      win_col    <= '0;
      win_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (first) begin
          width_r  <= w_clamp;
          height_r <= h_clamp;
          stride_r <= cfg_stride;
          cfg_err  <= w_err || h_err;
        end
        if (emit) begin
          out_valid <= 1'b1;
          win_data  <= win_next;
          win_row   <= row - RW'(K-1);
          win_col   <= col - CW'(K-1);
          win_last  <= (row == last_row) && (col == last_col);
        end
        // Phase 0 is pinned to index K-1, the first possible window origin + K-1
        if (end_col) begin
          col    <= '0;
          col_ph <= 1'b0;
          if (end_row) begin
            row        <= '0;
            row_ph     <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            row    <= row + RW'(1);
            row_ph <= (row == RW'(K-2)) ? 1'b0 : ~row_ph;
          end
        end else begin
          col    <= col + CW'(1);
          col_ph <= (col == CW'(K-2)) ? 1'b0 : ~col_ph;
        end
      end
    end
  end
endmodule

// File: tb/tb_window_gen_kxk.sv
// tb/tb_window_gen_kxk.sv - randomized and directed bench for window_gen_kxk against a frame-level window model
module tb_window_gen_kxk;
  localparam int DW = 8;
  localparam int KK = 3;
  localparam int CW = 7;
  localparam int RW = 7;

  typedef struct {
    logic [71:0] data;
    int          row;
    int          col;
    bit          last;
  } win_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cfg_width;
  logic [RW-1:0] cfg_height;
  logic          cfg_stride;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [71:0]   win_data;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          win_last;
  logic          out_valid;
  logic          out_ready;
  logic          frame_done;
  logic          cfg_err;

  window_gen_kxk #(.DATA_W(DW), .K(KK), .MAX_WIDTH(64), .MAX_HEIGHT(64)) dut (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_stride(cfg_stride), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .win_data(win_data), .win_row(win_row), .win_col(win_col), .win_last(win_last),
    .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  win_t        exp_q[$];
  win_t        obs_q[$];
  win_t        s1_q[$];
  logic [7:0]  pix [64][64];
  int          last_cnt;
  bit          mon_en = 0;
  bit          drv_last = 0;
  bit          fd_exp = 0;
  bit          held_v = 0;
  logic [71:0] held_d;
  logic [14:0] held_p;
  int          stall_seen = 0;
  int          rdy_mode = 0;
  int          stall_left = 0;

  task automatic chk_eq(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: every stride-aligned KxK origin, in raster order
  task automatic model_frame(input int w, input int h, input bit st, output int cnt);
    int   s;
    int   lr;
    int   lc;
    win_t e;
    s  = st ? 2 : 1;
    lr = ((h - KK) / s) * s;
    lc = ((w - KK) / s) * s;
    cnt = 0;
    for (int r0 = 0; r0 <= h - KK; r0 += s)
      for (int c0 = 0; c0 <= w - KK; c0 += s) begin
        e.data = '0;
        for (int r = 0; r < KK; r++)
          for (int c = 0; c < KK; c++)
            e.data[(r*KK+c)*8 +: 8] = pix[r0+r][c0+c];
        e.row  = r0;
        e.col  = c0;
        e.last = (r0 == lr) && (c0 == lc);
        exp_q.push_back(e);
        cnt++;
      end
  endtask

  task automatic send_pixel(input logic [7:0] d, input bit last, output bit ok);
    bit acc;
    in_data  = d;
    in_valid = 1'b1;
    drv_last = last;
    ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    drv_last = 1'b0;
  endtask

  task automatic run_frame(input int cw, input int ch, input bit st, input bit rnd,
                           input int off, input int gap, input int stop_after);
    int w;
    int h;
    int n;
    bit ok;
    w = (cw < KK) ? KK : ((cw > 64) ? 64 : cw);
    h = (ch < KK) ? KK : ((ch > 64) ? 64 : ch);
    cfg_width  = CW'(cw);
    cfg_height = RW'(ch);
    cfg_stride = st;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        pix[r][c] = rnd ? 8'($urandom) : 8'(r * 16 + c + off);
    last_cnt = 0;
    if (stop_after < 0) model_frame(w, h, st, last_cnt);
    n = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        if (stop_after >= 0 && n == stop_after) return;
        if (gap > 0 && $urandom_range(0, 99) < gap) begin
          @(posedge clk);
          #1;
        end
        send_pixel(pix[r][c], (r == h - 1) && (c == w - 1), ok);
        chk_eq("accept_timeout", 72'(ok), 72'd1);
        if (n == 0) begin
          chk_eq("cfg_err", 72'(cfg_err), 72'((cw < KK) || (cw > 64) || (ch < KK) || (ch > 64)));
          cfg_width  = CW'($urandom);
          cfg_height = RW'($urandom);
          cfg_stride = 1'($urandom);
        end
        n++;
      end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk_eq("drain_pending", 72'(exp_q.size()), 72'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (out_valid && stall_left > 0) begin
            out_ready  = 1'b0;
            stall_left = stall_left - 1;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    win_t e;
    if (mon_en) begin
      chk_eq("frame_done", 72'(frame_done), 72'(fd_exp));
      fd_exp = in_valid && in_ready && !rst && drv_last;
      chk_eq("in_ready", 72'(in_ready), 72'(!out_valid || out_ready));
      if (rst) begin
        held_v = 0;
      end else if (out_valid) begin
        if (held_v) begin
          chk_eq("hold_data", win_data, held_d);
          chk_eq("hold_pos", 72'({win_row, win_col, win_last}), 72'(held_p));
        end
        if (out_ready) begin
          held_v = 0;
          chk_eq("win_expected", 72'(exp_q.size() > 0), 72'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_eq("win_data", win_data, e.data);
            chk_eq("win_row", 72'(win_row), 72'(e.row));
            chk_eq("win_col", 72'(win_col), 72'(e.col));
            chk_eq("win_last", 72'(win_last), 72'(e.last));
          end
          e.data = win_data;
          e.row  = int'(win_row);
          e.col  = int'(win_col);
          e.last = win_last;
          obs_q.push_back(e);
        end else begin
          held_v = 1;
          held_d = win_data;
          held_p = {win_row, win_col, win_last};
          if (!in_ready) stall_seen++;
        end
      end else begin
        held_v = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    cfg_width = '0; cfg_height = '0; cfg_stride = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_out_valid", 72'(out_valid), 72'd0);
    chk_eq("rst_frame_done", 72'(frame_done), 72'd0);
    chk_eq("rst_cfg_err", 72'(cfg_err), 72'd0);
    chk_eq("rst_win_last", 72'(win_last), 72'd0);
    chk_eq("rst_win_data", win_data, 72'd0);
    chk_eq("rst_win_pos", 72'({win_row, win_col}), 72'd0);
    chk_eq("rst_in_ready", 72'(in_ready), 72'd1);
    rst = 1'b0;
    mon_en = 1;

    // 5x4 stride 1
    obs_q.delete();
    run_frame(5, 4, 0, 0, 0, 0, -1);
    chk_eq("s1_model_count", 72'(last_cnt), 72'd6);
    drain();
    chk_eq("s1_count", 72'(obs_q.size()), 72'd6);
    if (obs_q.size() == 6) begin
      chk_eq("s1_first_data", obs_q[0].data, 72'h222120121110020100);
      chk_eq("s1_first_pos", 72'({obs_q[0].row[6:0], obs_q[0].col[6:0], obs_q[0].last}), 72'd0);
      chk_eq("s1_last_data", obs_q[5].data, 72'h343332242322141312);
      chk_eq("s1_last_pos", 72'({obs_q[5].row[6:0], obs_q[5].col[6:0], obs_q[5].last}),
             72'({7'd1, 7'd2, 1'b1}));
    end
    s1_q = obs_q;

    // 5x4 stride 2
    obs_q.delete();
    run_frame(5, 4, 1, 0, 0, 0, -1);
    chk_eq("s2_model_count", 72'(last_cnt), 72'd2);
    drain();
    chk_eq("s2_count", 72'(obs_q.size()), 72'd2);
    if (obs_q.size() == 2) begin
      chk_eq("s2_w0_pos", 72'({obs_q[0].row[6:0], obs_q[0].col[6:0], obs_q[0].last}), 72'd0);
      chk_eq("s2_w1_pos", 72'({obs_q[1].row[6:0], obs_q[1].col[6:0], obs_q[1].last}),
             72'({7'd0, 7'd2, 1'b1}));
    end

    // consumer stall at the first window
    obs_q.delete();
    stall_seen = 0;
    stall_left = 10;
    rdy_mode = 2;
    run_frame(5, 4, 0, 0, 0, 0, -1);
    drain();
    rdy_mode = 0;
    chk_eq("s3_stall_cycles", 72'(stall_seen), 72'd10);
    chk_eq("s3_count", 72'(obs_q.size()), 72'd6);

    // two frames back to back
    obs_q.delete();
    run_frame(5, 4, 0, 0, 0, 0, -1);
    run_frame(5, 4, 0, 0, 8'h80, 0, -1);
    drain();
    chk_eq("s4_count", 72'(obs_q.size()), 72'd12);
    if (obs_q.size() == 12) begin
      chk_eq("s4_f2_first_data", obs_q[6].data, 72'hA2A1A0929190828180);
      chk_eq("s4_f2_first_pos", 72'({obs_q[6].row[6:0], obs_q[6].col[6:0]}), 72'd0);
    end

    // reset mid-frame then a fresh frame
    run_frame(5, 4, 0, 0, 0, 0, 7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("s5_out_valid", 72'(out_valid), 72'd0);
    chk_eq("s5_frame_done", 72'(frame_done), 72'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    run_frame(5, 4, 0, 0, 0, 0, -1);
    drain();
    chk_eq("s5_count", 72'(obs_q.size()), 72'(s1_q.size()));
    if (obs_q.size() == s1_q.size())
      for (int i = 0; i < obs_q.size(); i++)
        chk_eq("s5_match_s1", obs_q[i].data, s1_q[i].data);

    // clamped config
    obs_q.delete();
    run_frame(2, 70, 0, 0, 0, 0, -1);
    chk_eq("s6_model_count", 72'(last_cnt), 72'd62);
    drain();
    chk_eq("s6_cfg_err_held", 72'(cfg_err), 72'd1);
    chk_eq("s6_count", 72'(obs_q.size()), 72'd62);
    if (obs_q.size() > 0) begin
      chk_eq("s6_first_data", obs_q[0].data, 72'h222120121110020100);
      chk_eq("s6_first_pos", 72'({obs_q[0].row[6:0], obs_q[0].col[6:0]}), 72'd0);
    end

    // randomized frames with gaps and backpressure
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      int cw;
      int ch;
      cw = ($urandom_range(0, 7) == 0) ? 70 : $urandom_range(0, 12);
      ch = $urandom_range(0, 10);
      run_frame(cw, ch, 1'($urandom), 1, 0, 30, -1);
    end
    drain();
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
